if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 120 ++++++++++++
 tb/tb_if_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: fetch PC register and IF/ID pipeline register.
// Define IF_STAGE_PERF_CNT_EN to add the fetch_count/bubble_count outputs.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus_4_in,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus_4,
  output logic        ifid_valid,
  output logic        misalign_err,
  output logic        fsm_state
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  // Handshake: there is no valid/ready pair here; stall holds every register,
  // redirect overrides stall, and ifid_valid marks a real instruction to decode.

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  logic do_redirect;
  logic do_advance;
  logic do_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      BOOT:    next_state = RUN;
      RUN:     next_state = RUN;
      default: next_state = BOOT;
    endcase
  end

  // BOOT ignores stall and redirect; in RUN redirect beats stall beats advance.
  always_comb begin
    do_redirect = 1'b0;
    do_advance  = 1'b0;
    do_bubble   = 1'b0;
    case (state)
      BOOT: do_bubble = 1'b1;
      RUN: begin
        do_redirect = redirect;
        do_bubble   = redirect;
        do_advance  = !redirect && !stall;
      end
      default: do_bubble = 1'b1;
    endcase
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      ifid_instr     <= NOP_INSTR;
      ifid_pc_plus_4 <= 32'h0000_0000;
      ifid_valid     <= 1'b0;
      misalign_err   <= 1'b0;
    end else begin
      misalign_err <= do_redirect && (redirect_target[1:0] != 2'b00);
      if (do_redirect) begin
        pc <= {redirect_target[31:2], 2'b00};
      end else if (do_advance) begin
        // Low bits are forced so the fetch PC stays word aligned.
        pc <= {pc_plus_4_in[31:2], 2'b00};
      end
      if (do_bubble) begin
        ifid_instr     <= NOP_INSTR;
        ifid_pc_plus_4 <= 32'h0000_0000;
        ifid_valid     <= 1'b0;
      end else if (do_advance) begin
        ifid_instr     <= instr_in;
        ifid_pc_plus_4 <= pc_plus_4_in;
        ifid_valid     <= 1'b1;
      end
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count  <= 32'h0000_0000;
      bubble_count <= 32'h0000_0000;
    end else begin
      if (do_advance) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (do_bubble) begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a cycle model of the fetch rules compared every cycle,
// plus directed scenarios with literal expectations.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] instr_in;
  logic [31:0] pc_plus_4_in;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus_4;
  logic        ifid_valid;
  logic        misalign_err;
  logic        fsm_state;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .instr_in       (instr_in),
    .pc_plus_4_in   (pc_plus_4_in),
    .pc             (pc),
    .ifid_instr     (ifid_instr),
    .ifid_pc_plus_4 (ifid_pc_plus_4),
    .ifid_valid     (ifid_valid),
    .misalign_err   (misalign_err),
    .fsm_state      (fsm_state)
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count)
`endif
  );

  // Instruction memory and PC adder sit outside the stage, driven from pc.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign instr_in     = mem(pc);
  assign pc_plus_4_in = pc + 32'd4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model of the fetch rules.
  logic [31:0] m_pc, m_instr, m_p4, m_fetches, m_bubbles;
  logic        m_valid, m_err;
  bit          m_boot;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_err = 1'b0;
      m_boot = 1'b1; m_fetches = 32'h0; m_bubbles = 32'h0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_err = 1'b0;
      m_bubbles = m_bubbles + 1;
    end else if (redirect) begin
      m_err = (redirect_target % 4) != 0;
      m_pc = redirect_target - (redirect_target % 4);
      m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0;
      m_bubbles = m_bubbles + 1;
    end else if (stall) begin
      m_err = 1'b0;
    end else begin
      m_instr = mem(m_pc);
      m_p4 = m_pc + 4;
      m_pc = m_pc + 4;
      m_valid = 1'b1;
      m_err = 1'b0;
      m_fetches = m_fetches + 1;
    end
  end

  // scoreboard: compare every cycle away from the active edge
  always @(negedge clk) begin
    if (run_chk) begin
      chk("pc", pc, m_pc);
      chk("pc_align", {30'h0, pc[1:0]}, 32'h0);
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_pc_plus_4", ifid_pc_plus_4, m_p4);
      chk("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
      chk("misalign_err", {31'h0, misalign_err}, {31'h0, m_err});
`ifdef IF_STAGE_PERF_CNT_EN
      chk("fetch_count", fetch_count, m_fetches);
      chk("bubble_count", bubble_count, m_bubbles);
`endif
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] t);
    #1;
    stall = s;
    redirect = r;
    redirect_target = t;
  endtask

  logic [11:0] tbl_s = 12'b0101_1001_0110;
  logic [11:0] tbl_r = 12'b0011_0100_1010;
  logic [31:0] tbl_t [0:11] = '{32'h100, 32'h203, 32'h7F8, 32'h011, 32'h400, 32'h402,
                                32'h55C, 32'h001, 32'hABC, 32'h30E, 32'h900, 32'hFFF};

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", {31'h0, ifid_valid}, 32'h0);
    chk("reset_state", {31'h0, fsm_state}, 32'h0);
    run_chk = 1'b1;
    #1 rst_n = 1'b1;
    #2 chk("no_change_before_edge", pc, 32'h0);

    // Reset then three advances: pc 0,0,4,8,C.
    tick(); chk("boot_pc", pc, 32'h0); chk("boot_valid", {31'h0, ifid_valid}, 32'h0);
    chk("run_state", {31'h0, fsm_state}, 32'h1);
    tick(); chk("adv1_pc", pc, 32'h4); chk("adv1_instr", ifid_instr, 32'h1357_9BDF);
    chk("adv1_p4", ifid_pc_plus_4, 32'h4);
    tick(); chk("adv2_pc", pc, 32'h8);
    drive(1'b1, 1'b0, 32'h0);
    tick(); chk("stall1_pc", pc, 32'h8); chk("stall1_p4", ifid_pc_plus_4, 32'h8);
    tick(); chk("stall2_pc", pc, 32'h8); chk("stall2_instr", ifid_instr, 32'h1357_9BDB);
    drive(1'b0, 1'b0, 32'h0);
    tick(); chk("resume_pc", pc, 32'hC);

    // Redirect wins over stall.
    drive(1'b1, 1'b1, 32'h0000_0040);
    tick(); chk("redir_pc", pc, 32'h40); chk("redir_valid", {31'h0, ifid_valid}, 32'h0);
    chk("redir_err", {31'h0, misalign_err}, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    tick(); chk("post_redir_pc", pc, 32'h44);

    // Misaligned target.
    drive(1'b0, 1'b1, 32'h0000_0046);
    tick(); chk("mis_pc", pc, 32'h44); chk("mis_err", {31'h0, misalign_err}, 32'h1);
    drive(1'b0, 1'b0, 32'h0);
    tick(); chk("mis_err_clear", {31'h0, misalign_err}, 32'h0); chk("mis_next_pc", pc, 32'h48);

    // PC wrap.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC);
    tick(); chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0);
    tick(); chk("wrap_pc", pc, 32'h0); chk("wrap_p4", ifid_pc_plus_4, 32'h0);
    chk("wrap_valid", {31'h0, ifid_valid}, 32'h1);

    // Directed table, checked by the model.
    for (int i = 0; i < 12; i++) begin
      drive(tbl_s[i], tbl_r[i], tbl_t[i]);
      tick();
    end

    // Async reset asserted mid-stall and mid-redirect.
    drive(1'b1, 1'b1, 32'h0000_0123);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_pc", pc, 32'h0); chk("async_valid", {31'h0, ifid_valid}, 32'h0);
    chk("async_err", {31'h0, misalign_err}, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #2 chk("rel_hold_pc", pc, 32'h0);
    tick(); chk("reboot_pc", pc, 32'h0); chk("reboot_valid", {31'h0, ifid_valid}, 32'h0);
    drive(1'b0, 1'b0, 32'h0);

    // Counters after reset, 4 advances, 1 redirect.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    repeat (4) tick();
    drive(1'b0, 1'b1, 32'h0000_0200);
    tick();
    drive(1'b0, 1'b0, 32'h0);
`ifdef IF_STAGE_PERF_CNT_EN
    chk("lit_fetch_count", fetch_count, 32'd4);
    chk("lit_bubble_count", bubble_count, 32'd2);
`endif
    chk("cnt_seq_pc", pc, 32'h200);
    tick();
    run_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
